bnn_fc_layer_seq: RTL and testbench
===================================

Name: bnn_fc_layer_seq

Overview:
- Folded, parametrised binary fully-connected layer engine: XNOR-popcount-threshold over IN_W input bits for OUT_N neurons.
- Computes PAR neurons per cycle and streams weights/thresholds from external synchronous memory, instead of instantiating one neuron per output.
- Sits between the input latch and the next layer (or classifier) in the BNN datapath.
- Uses valid/ready handshakes on both sides.

Parameters:
- IN_W, 784, input vector width in bits.
- OUT_N, 256, number of neurons (output bits).
- PAR, 16, neurons evaluated per cycle; OUT_N % PAR must be 0, otherwise elaboration fails.
- CNT_W, $clog2(IN_W+1), popcount/threshold width.
- G (localparam), OUT_N/PAR, number of groups.
- AW (localparam), max(1,$clog2(G)), weight address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  upstream vector valid
- o_ready  out  1  block can accept a vector
- i_data  in  IN_W  input activation bits
- w_rd_en  out  1  weight/threshold memory read strobe
- w_addr  out  AW  group index being read
- w_data  in  PAR*IN_W  weights for group; slice j = w_data[j*IN_W +: IN_W]; 1-cycle read latency
- th_data  in  PAR*CNT_W  thresholds for group, slice j = th_data[j*CNT_W +: CNT_W]; same address and latency as w_data
- o_valid  out  1  result valid
- i_ready  in  1  downstream ready
- o_bits  out  OUT_N  binarised neuron outputs; neuron n on bit n

Behaviour:
- Reset: while rst is high, all registers clear on the clock edge and the in-flight w_data is discarded. After reset: state IDLE, o_valid=0, o_bits=0, w_rd_en=0, w_addr=0. o_ready is 0 during any cycle with rst high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On an edge with i_valid&&o_ready, latch i_data into an internal register, clear group counters, and go to RUN. Call this edge E0.
- RUN:
  - o_ready=0.
  - Issue counter a steps from 0 to G-1. In the cycle after edge E(k) (k=0..G-1): w_rd_en=1, w_addr=k.
  - Memory returns w_data/th_data for group k during the cycle after E(k+1).
  - At edge E(k+2), write the PAR result bits into o_bits[k*PAR +: PAR].
  - w_rd_en=0 once all G addresses have been issued.
  - At E(G+1), go to DONE and set o_valid=1. Latency is G+1 edges from the accept edge.
- Neuron j of group k:
  - pc = popcount(~(x ^ w_j)), an IN_W-bit count.
  - bit = (pc >= th_j), unsigned compare.
  - th=0 always gives 1; th>IN_W always gives 0.
  - The popcount is combinational over one cycle. A balanced adder tree is acceptable.
- DONE:
  - o_valid=1; o_bits is held stable.
  - o_ready=0; i_valid is ignored.
  - On an edge with o_valid&&i_ready, go to IDLE and clear o_valid. o_ready=1 in the next cycle.
  - o_bits keeps its last value until it is overwritten by the next run.
- G=1 is legal: one address cycle, o_valid at E2.
- A reset asserted in RUN or DONE aborts the run: no o_valid, and w_rd_en=0 from the next cycle.
- No overlap between transactions: a new vector is accepted only in IDLE.

Optional Feature:
- Macro: BNN_ARGMAX_EN.
- When defined, adds two output ports:
  - o_class, width max(1,$clog2(OUT_N)): index of the neuron with the largest raw pc.
  - o_max, width CNT_W: that pc value.
- Argmax is tracked as a running value across groups and within each group. Ties resolve to the lowest index. Both values reset to 0, clear at accept, and are valid and held alongside o_valid.
- When undefined, these ports and their logic are absent, and the behaviour is otherwise identical.

Test Plan:
Config for all scenarios: IN_W=8, OUT_N=8, PAR=4 (G=2); the memory model has 1-cycle latency.
1. Reset held 3 cycles then released -> o_valid=0, o_bits=0, w_rd_en=0 during reset; o_ready=1 on the first cycle after release.
2. i_data=8'hFF, all weights 8'hFF, all thresholds 8 -> w_addr 0 then 1 on consecutive cycles with w_rd_en=1; o_valid rises 3 edges after accept; o_bits=8'hFF.
3. i_data=8'h00, weights 8'hFF (pc=0), thresholds 0 for neurons 0-3 and 1 for neurons 4-7 -> o_bits=8'h0F.
4. Backpressure: as scenario 2 but i_ready=0 for 5 cycles after o_valid -> o_valid and o_bits held, o_ready=0, pulses on i_valid ignored; after i_ready=1 handshake, o_valid=0 and o_ready=1 next cycle, and a second vector completes correctly.
5. rst pulsed for 1 cycle while w_addr=1 -> no o_valid, w_rd_en=0 next cycle, o_bits=0; the next transaction gives correct o_bits.
6. BNN_ARGMAX_EN defined; weights chosen so pc = {3,5,7,2,1,7,0,4} for neurons 0..7 -> o_class=2, o_max=7, asserted with o_valid.

Source files
------------

// File: rtl/bnn_fc_layer_seq.sv
// Folded binary fully-connected layer: XNOR-popcount-threshold, PAR neurons per cycle,
// weights/thresholds streamed from a 1-cycle-latency memory. Optional argmax via BNN_ARGMAX_EN.
module bnn_fc_layer_seq #(
  parameter int unsigned IN_W  = 784,
  parameter int unsigned OUT_N = 256,
  parameter int unsigned PAR   = 16,
  parameter int unsigned CNT_W = $clog2(IN_W + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [IN_W-1:0]                   i_data,
  output logic                              w_rd_en,
  output logic [((OUT_N/PAR > 1) ? $clog2(OUT_N/PAR) : 1)-1:0] w_addr,
  input  logic [PAR*IN_W-1:0]               w_data,
  input  logic [PAR*CNT_W-1:0]              th_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [OUT_N-1:0]                  o_bits
`ifdef BNN_ARGMAX_EN
  ,
  output logic [((OUT_N > 1) ? $clog2(OUT_N) : 1)-1:0] o_class,
  output logic [CNT_W-1:0]                  o_max
`endif
);

  localparam int unsigned G  = OUT_N / PAR;
  localparam int unsigned AW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned IW = $clog2(G + 1);

  generate
    if (OUT_N % PAR != 0) begin : g_par_check
      $error("OUT_N must be a multiple of PAR");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   x_q;
  logic [IW-1:0]     iss_q;
  logic              rsp_vld_q;
  logic [AW-1:0]     rsp_grp_q;
  logic [OUT_N-1:0]  bits_q;
  logic              accept;
  logic              last_rsp;

  logic [CNT_W-1:0]  pc [PAR];
  logic [PAR-1:0]    res;

  // One XNOR-popcount and threshold compare per lane, over the group currently on w_data.
  always_comb begin
    logic [IN_W-1:0] xn;
    xn  = '0;
    res = '0;
    for (int j = 0; j < PAR; j++) begin
      xn    = ~(x_q ^ w_data[j*IN_W +: IN_W]);
      pc[j] = '0;
      for (int i = 0; i < IN_W; i++) begin
        pc[j] = pc[j] + CNT_W'(xn[i]);
      end
      res[j] = (pc[j] >= th_data[j*CNT_W +: CNT_W]);
    end
  end

  assign accept   = (state_q == StIdle) && i_valid;
  assign last_rsp = rsp_vld_q && (rsp_grp_q == AW'(G - 1));
  assign w_addr   = iss_q[AW-1:0];
  assign o_valid  = (state_q == StDone);
  assign o_bits   = bits_q;

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    w_rd_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_ready = !rst;
        if (i_valid) state_d = StRun;
      end
      StRun: begin
        w_rd_en = (iss_q != IW'(G));
        if (last_rsp) state_d = StDone;
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      iss_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_grp_q <= '0;
      bits_q    <= '0;
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= w_rd_en;
      rsp_grp_q <= w_addr;
      if (accept) begin
        x_q   <= i_data;
        iss_q <= '0;
      end else if (w_rd_en) begin
        iss_q <= iss_q + 1'b1;
      end
      if (rsp_vld_q) bits_q[rsp_grp_q*PAR +: PAR] <= res;
    end
  end

`ifdef BNN_ARGMAX_EN
  localparam int unsigned CW = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  logic [CNT_W-1:0] max_q, max_d;
  logic [CW-1:0]    cls_q, cls_d;

  // Strict greater-than while scanning in ascending index order keeps ties on the lowest index.
  always_comb begin
    max_d = max_q;
    cls_d = cls_q;
    for (int j = 0; j < PAR; j++) begin
      if (pc[j] > max_d) begin
        max_d = pc[j];
        cls_d = CW'(rsp_grp_q * PAR + j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      max_q <= '0;
      cls_q <= '0;
    end else if (rsp_vld_q) begin
      max_q <= max_d;
      cls_q <= cls_d;
    end
  end

  assign o_class = cls_q;
  assign o_max   = max_q;
`endif

endmodule

// File: tb/tb_bnn_fc_layer_seq.sv
// Scoreboard bench for bnn_fc_layer_seq (IN_W=8, OUT_N=8, PAR=4); argmax checked with BNN_ARGMAX_EN.
module tb_bnn_fc_layer_seq;
  localparam int IN_W  = 8;
  localparam int OUT_N = 8;
  localparam int PAR   = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   i_valid = 1'b0;
  logic                   i_ready = 1'b1;
  logic [IN_W-1:0]        i_data = '0;
  logic                   o_ready;
  logic                   w_rd_en;
  logic [0:0]             w_addr;
  logic [PAR*IN_W-1:0]    w_data = '0;
  logic [PAR*CNT_W-1:0]   th_data = '0;
  logic                   o_valid;
  logic [OUT_N-1:0]       o_bits;
`ifdef BNN_ARGMAX_EN
  logic [2:0]             o_class;
  logic [CNT_W-1:0]       o_max;
`endif

  bnn_fc_layer_seq #(.IN_W(IN_W), .OUT_N(OUT_N), .PAR(PAR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .th_data(th_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_bits(o_bits)
`ifdef BNN_ARGMAX_EN
    , .o_class(o_class), .o_max(o_max)
`endif
  );

  always #5 clk = ~clk;

  logic [IN_W-1:0]  wmem  [OUT_N];
  logic [CNT_W-1:0] thmem [OUT_N];

  // Synchronous memory, one cycle of read latency.
  always @(posedge clk) begin
    if (w_rd_en) begin
      for (int j = 0; j < PAR; j++) begin
        w_data[j*IN_W +: IN_W]   <= wmem[int'(w_addr)*PAR + j];
        th_data[j*CNT_W +: CNT_W] <= thmem[int'(w_addr)*PAR + j];
      end
    end
  end

  typedef struct packed {
    logic [OUT_N-1:0] bits;
    logic [2:0]       cls;
    logic [3:0]       mx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every neuron's agreement count, threshold, then first index of the maximum.
  function automatic exp_t model(input logic [IN_W-1:0] x);
    exp_t e;
    int   pcs [OUT_N];
    int   mx;
    logic [IN_W-1:0] agree;
    e  = '0;
    mx = 0;
    for (int n = 0; n < OUT_N; n++) begin
      agree     = ~(x ^ wmem[n]);
      pcs[n]    = $countones(agree);
      e.bits[n] = (pcs[n] >= int'(thmem[n]));
      if (pcs[n] > mx) mx = pcs[n];
    end
    e.mx = 4'(mx);
    for (int n = OUT_N - 1; n >= 0; n--) begin
      if (pcs[n] == mx) e.cls = 3'(n);
    end
    return e;
  endfunction

  // Monitor: compare whenever a result handshake is about to happen.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got o_bits %0h expected no result", o_bits);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("o_bits", 32'(o_bits), 32'(e.bits));
`ifdef BNN_ARGMAX_EN
        chk("o_class", 32'(o_class), 32'(e.cls));
        chk("o_max", 32'(o_max), 32'(e.mx));
`endif
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] x, input bit push, input bit timing);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("o_ready_wait", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_data  = x;
    @(posedge clk);
    #1 i_valid = 1'b0;
    if (push) sb.push_back(model(x));
    if (timing) begin
      @(negedge clk);
      chk("rd_en_c1", 32'(w_rd_en), 32'd1);
      chk("addr_c1", 32'(w_addr), 32'd0);
      chk("o_ready_run", 32'(o_ready), 32'd0);
      @(negedge clk);
      chk("rd_en_c2", 32'(w_rd_en), 32'd1);
      chk("addr_c2", 32'(w_addr), 32'd1);
      @(negedge clk);
      chk("rd_en_c3", 32'(w_rd_en), 32'd0);
      chk("o_valid_c3", 32'(o_valid), 32'd0);
      @(negedge clk);
      chk("o_valid_c4", 32'(o_valid), 32'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic fill(input logic [IN_W-1:0] w, input logic [CNT_W-1:0] th_lo,
                      input logic [CNT_W-1:0] th_hi);
    for (int n = 0; n < OUT_N; n++) begin
      wmem[n]  = w;
      thmem[n] = (n < 4) ? th_lo : th_hi;
    end
  endtask

  initial begin
    int          pcv [OUT_N];
    int          n;
    logic [7:0]  ones;
    bit          seen;

    fill(8'hFF, 4'd8, 4'd8);
    // Reset held three cycles.
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_bits", 32'(o_bits), 32'd0);
      chk("rst_rd_en", 32'(w_rd_en), 32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_o_ready", 32'(o_ready), 32'd1);

    // All-ones vector and weights, threshold at the full count.
    send(8'hFF, 1'b1, 1'b1);
    drain();

    // Zero agreement against thresholds 0 and 1.
    fill(8'hFF, 4'd0, 4'd1);
    send(8'h00, 1'b1, 1'b0);
    drain();

    // Backpressure.
    fill(8'hFF, 4'd8, 4'd8);
    @(posedge clk);
    #1 i_ready = 1'b0;
    send(8'hFF, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_o_valid_rise", 32'(o_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 i_valid = c[0];
      i_data = 8'h00;
      @(negedge clk);
      chk("bp_o_valid_hold", 32'(o_valid), 32'd1);
      chk("bp_o_bits_hold", 32'(o_bits), 32'hFF);
      chk("bp_o_ready", 32'(o_ready), 32'd0);
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_o_valid_clear", 32'(o_valid), 32'd0);
    chk("bp_o_ready_back", 32'(o_ready), 32'd1);
    drain();
    fill(8'hFF, 4'd0, 4'd1);
    send(8'h00, 1'b1, 1'b0);
    drain();

    // Reset during the second address cycle aborts the run.
    fill(8'hFF, 4'd8, 4'd8);
    send(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_addr", 32'(w_addr), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", 32'(w_rd_en), 32'd0);
    chk("abort_o_bits", 32'(o_bits), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    fill(8'h5A, 4'd4, 4'd5);
    send(8'h3C, 1'b1, 1'b0);
    drain();

    // Argmax pattern: pc = {3,5,7,2,1,7,0,4}.
    pcv = '{3, 5, 7, 2, 1, 7, 0, 4};
    for (int k = 0; k < OUT_N; k++) begin
      ones     = 8'((32'd1 << pcv[k]) - 1);
      wmem[k]  = ~ones;
      thmem[k] = 4'($urandom_range(0, 9));
    end
    send(8'h00, 1'b1, 1'b0);
    drain();

    // Randomised transactions with random downstream stalls.
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < OUT_N; k++) begin
        wmem[k]  = 8'($urandom);
        thmem[k] = 4'($urandom_range(0, 10));
      end
      send(8'($urandom), 1'b1, 1'b0);
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk);
        #1 i_ready = 1'($urandom_range(0, 1));
        n++;
      end
      i_ready = 1'b1;
      chk("rand_done", 32'(sb.size()), 32'd0);
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
